// File: rtl/array_uart_receiver.sv
// array_uart_receiver: 8N1 UART receiver that packs consecutive bytes into a
// DATA_WIDTH-bit word. The first byte lands in the top byte lane.
//
// Ports:
//   clk         - single clock, rising edge
//   rst_n       - asynchronous active-low reset
//   uart_rx     - asynchronous serial line, idle high
//   data_array  - last complete word; holds its value between completions
//   data_valid  - one-cycle pulse when data_array takes a new word
//   frame_error - one-cycle pulse when a stop bit is sampled low
//   busy        - high whenever the receiver is not idle
//
// Optional feature: define ARRAY_UART_RX_TIMEOUT_EN to drop a partial word
// after TIMEOUT_BITS bit periods of idle line.
`timescale 1ns/1ps
module array_uart_receiver #(
  parameter int unsigned CLOCK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic [DATA_WIDTH-1:0] data_array,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int unsigned ClksPerBit = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned NumBytes   = DATA_WIDTH / 8;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned BcW        = $clog2(NumBytes + 1);

  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [BcW-1:0]  ByteLast = BcW'(NumBytes - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StStart   = 3'd1;
  localparam logic [2:0] StData    = 3'd2;
  localparam logic [2:0] StStop    = 3'd3;
  localparam logic [2:0] StRecover = 3'd4;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || TIMEOUT_BITS < 1) begin : g_bad_params
    $error("DATA_WIDTH must be a nonzero multiple of 8 and TIMEOUT_BITS at least 1");
  end

  logic                  rx_meta_q, rx_sync_q;
  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic [BcW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] array_sh_q, array_sh_d;
  logic [DATA_WIDTH-1:0] data_array_q, data_array_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_error_q, frame_error_d;

`ifdef ARRAY_UART_RX_TIMEOUT_EN
  localparam logic [31:0] TimeoutClks = 32'(TIMEOUT_BITS * ClksPerBit);
  logic [31:0] idle_cnt_q, idle_cnt_d;
`endif

  // Two-flop synchronizer; flops reset to the idle-line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_idx_d     = bit_idx_q;
    rx_byte_d     = rx_byte_q;
    byte_cnt_d    = byte_cnt_q;
    array_sh_d    = array_sh_q;
    data_array_d  = data_array_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d   = StStart;
          clk_cnt_d = '0;
        end
      end
      StStart: begin
        // Mid-start-bit sample rejects glitches shorter than half a bit.
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            state_d = StIdle;
            if (byte_cnt_q == ByteLast) begin
              data_array_d = (array_sh_q << 8) | DATA_WIDTH'(rx_byte_q);
              data_valid_d = 1'b1;
              byte_cnt_d   = '0;
              array_sh_d   = '0;
            end else begin
              array_sh_d = (array_sh_q << 8) | DATA_WIDTH'(rx_byte_q);
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else begin
            // Bad stop bit poisons the whole word in progress.
            frame_error_d = 1'b1;
            byte_cnt_d    = '0;
            array_sh_d    = '0;
            state_d       = StRecover;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StRecover: begin
        if (rx_sync_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef ARRAY_UART_RX_TIMEOUT_EN
    // Runs only while idle with a partial word; a falling edge starts a new
    // byte instead, so the two never update byte_cnt_d in the same cycle.
    idle_cnt_d = '0;
    if (state_q == StIdle && rx_sync_q && byte_cnt_q != '0) begin
      if (idle_cnt_q > TimeoutClks) begin
        byte_cnt_d = '0;
        array_sh_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      rx_byte_q     <= '0;
      byte_cnt_q    <= '0;
      array_sh_q    <= '0;
      data_array_q  <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      rx_byte_q     <= rx_byte_d;
      byte_cnt_q    <= byte_cnt_d;
      array_sh_q    <= array_sh_d;
      data_array_q  <= data_array_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

`ifdef ARRAY_UART_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign data_array  = data_array_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != StIdle);

endmodule
